// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the instruction-bus req/gnt/rvalid
// handshake and presents one held instruction to IF/ID, discarding responses of killed fetches.
module if_fetch_unit #(
  parameter int                 ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = 'h8000_0000,
  parameter logic [31:0]        NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_fetch_dont_fetch_i,
  input  logic              if_fetch_flush_i,
  input  logic              if_fetch_redirect_i,
  input  logic [ADDR_W-1:0] if_fetch_redirect_pc_i,
  input  logic              if_fetch_advance_i,
  output logic              if_fetch_req_o,
  output logic [ADDR_W-1:0] if_fetch_addr_o,
  input  logic              if_fetch_gnt_i,
  input  logic              if_fetch_rvalid_i,
  input  logic [63:0]       if_fetch_rdata_i,
  output logic              if_fetch_fetched_ok_o,
  output logic [31:0]       if_fetch_inst_o,
  output logic [ADDR_W-1:0] if_fetch_pc_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic              r_drop_pend, w_drop_pend_nxt;
  logic              r_redir_pend, w_redir_pend_nxt;
  logic [ADDR_W-1:0] r_redir_pc, w_redir_pc_nxt;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_pc_o;

  logic              w_kill;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_capture;
  logic              w_clear_inst;

  assign w_kill     = if_fetch_flush_i | if_fetch_redirect_i;
  assign w_redir_pc = {if_fetch_redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign w_pc_inc   = r_pc + ADDR_W'(4);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drop_pend_nxt  = r_drop_pend;
    w_redir_pend_nxt = r_redir_pend;
    w_redir_pc_nxt   = r_redir_pc;
    w_capture        = 1'b0;
    w_clear_inst     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (if_fetch_redirect_i) begin
          w_pc_nxt = w_redir_pc;
        end else if (!if_fetch_dont_fetch_i && !w_kill) begin
          w_state_nxt = S_REQ;
        end
      end

      S_REQ: begin
        if (if_fetch_gnt_i) begin
          // The address was on the bus until this handshake; only now may the PC move.
          w_drop_pend_nxt  = 1'b0;
          w_redir_pend_nxt = 1'b0;
          if (if_fetch_redirect_i) begin
            w_pc_nxt = w_redir_pc;
          end else if (r_redir_pend) begin
            w_pc_nxt = r_redir_pc;
          end
          w_state_nxt = (w_kill || r_drop_pend) ? S_DROP : S_WAIT;
        end else if (w_kill) begin
          w_drop_pend_nxt = 1'b1;
          if (if_fetch_redirect_i) begin
            w_redir_pend_nxt = 1'b1;
            w_redir_pc_nxt   = w_redir_pc;
          end
        end
      end

      S_WAIT: begin
        if (if_fetch_redirect_i) begin
          w_pc_nxt = w_redir_pc;
        end
        if (if_fetch_rvalid_i) begin
          w_state_nxt = w_kill ? S_IDLE : S_HOLD;
          w_capture   = !w_kill;
        end else if (w_kill) begin
          w_state_nxt = S_DROP;
        end
      end

      S_HOLD: begin
        if (w_kill) begin
          w_clear_inst = 1'b1;
          w_state_nxt  = S_IDLE;
          if (if_fetch_redirect_i) begin
            w_pc_nxt = w_redir_pc;
          end else if (if_fetch_advance_i) begin
            w_pc_nxt = w_pc_inc;
          end
        end else if (if_fetch_advance_i) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = if_fetch_dont_fetch_i ? S_IDLE : S_REQ;
        end
      end

      S_DROP: begin
        if (if_fetch_redirect_i) begin
          w_pc_nxt = w_redir_pc;
        end
        if (if_fetch_rvalid_i) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drop_pend  <= 1'b0;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= '0;
      r_inst       <= NOP_INST;
      r_pc_o       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drop_pend  <= w_drop_pend_nxt;
      r_redir_pend <= w_redir_pend_nxt;
      r_redir_pc   <= w_redir_pc_nxt;
      if (w_capture) begin
        r_inst <= r_pc[2] ? if_fetch_rdata_i[63:32] : if_fetch_rdata_i[31:0];
        r_pc_o <= r_pc;
      end else if (w_clear_inst) begin
        r_inst <= NOP_INST;
      end
    end
  end

  assign if_fetch_req_o        = (r_state == S_REQ);
  assign if_fetch_addr_o       = {r_pc[ADDR_W-1:3], 3'b000};
  assign if_fetch_fetched_ok_o = (r_state == S_HOLD);
  assign if_fetch_inst_o       = r_inst;
  assign if_fetch_pc_o         = r_pc_o;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a small bus responder plus a scoreboard of expected
// fetches (pc, inst) pushed by each scenario and popped when fetched_ok rises.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        dont_fetch, flush, redirect, advance, gnt, rvalid;
  logic [63:0] redirect_pc, rdata;
  logic        req, ok;
  logic [63:0] addr, pc_o;
  logic [31:0] inst;

  int unsigned n_vec;
  int unsigned n_err;
  exp_t        sb_q[$];

  logic        prev_ok;
  logic [31:0] held_inst;
  logic [63:0] held_pc;
  logic        pend;
  int          cnt;
  int          rv_delay;
  logic [63:0] paddr;

  if_fetch_unit dut (
    .clk                    (clk),
    .rst                    (rst),
    .if_fetch_dont_fetch_i  (dont_fetch),
    .if_fetch_flush_i       (flush),
    .if_fetch_redirect_i    (redirect),
    .if_fetch_redirect_pc_i (redirect_pc),
    .if_fetch_advance_i     (advance),
    .if_fetch_req_o         (req),
    .if_fetch_addr_o        (addr),
    .if_fetch_gnt_i         (gnt),
    .if_fetch_rvalid_i      (rvalid),
    .if_fetch_rdata_i       (rdata),
    .if_fetch_fetched_ok_o  (ok),
    .if_fetch_inst_o        (inst),
    .if_fetch_pc_o          (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: one fixed doubleword at the reset PC, elsewhere each word holds its own address.
  function automatic logic [63:0] mem(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h00A00093_00000513;
    return {a[31:0] | 32'h4, a[31:0]};
  endfunction

  function automatic exp_t mk(input logic [63:0] p);
    exp_t        e;
    logic [63:0] d;
    d      = mem({p[63:3], 3'b000});
    e.pc   = p;
    e.inst = p[2] ? d[63:32] : d[31:0];
    return e;
  endfunction

  // One clock: note a handshake, advance to the negedge, score fetches, then drive the bus response.
  task automatic cycle();
    logic        hs;
    logic [63:0] ha;
    exp_t        e;
    hs = req & gnt & !rst;
    ha = addr;
    @(negedge clk);
    if (ok && !prev_ok) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_fetch: got pc=%h inst=%h, none expected", pc_o, inst);
      end else begin
        e = sb_q.pop_front();
        if (inst !== e.inst || pc_o !== e.pc) begin
          n_err++;
          $display("FAIL fetch: got pc=%h inst=%h, want pc=%h inst=%h", pc_o, inst, e.pc, e.inst);
        end
      end
      held_inst = inst;
      held_pc   = pc_o;
    end else if (ok && prev_ok) begin
      n_vec++;
      if (inst !== held_inst || pc_o !== held_pc) begin
        n_err++;
        $display("FAIL hold_stable: got pc=%h inst=%h, want pc=%h inst=%h", pc_o, inst, held_pc, held_inst);
      end
    end
    prev_ok = ok;
    rvalid  = 1'b0;
    rdata   = 64'h0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (hs) begin
        pend  = 1'b1;
        cnt   = rv_delay;
        paddr = ha;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          rvalid = 1'b1;
          rdata  = mem(paddr);
          pend   = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_ok(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (ok) break;
      cycle();
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_ok_timeout: fetched_ok=%b after %0d cycles, want 1", ok, max_cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    n_vec++;
    if ({req, ok} !== 2'b00 || inst !== NOP || pc_o !== 64'h0) begin
      n_err++;
      $display("FAIL reset_state: got req=%b ok=%b inst=%h pc=%h, want 0 0 %h 0", req, ok, inst, pc_o, NOP);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    cycle();
    n_vec++;
    if (req !== 1'b1 || addr !== 64'h8000_0000) begin
      n_err++;
      $display("FAIL first_req: got req=%b addr=%h, want 1 80000000", req, addr);
    end
    sb_q.push_back(mk(64'h8000_0000));
    cycle();
    n_vec++;
    if (req !== 1'b0) begin
      n_err++;
      $display("FAIL req_drop_after_gnt: got req=%b, want 0", req);
    end
    cycle();
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_latency: got fetched_ok=%b 2 cycles after req, want 1", ok);
    end
  endtask

  task automatic test_hold_advance();
    advance = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_vec++;
      if (ok !== 1'b1 || req !== 1'b0) begin
        n_err++;
        $display("FAIL hold: got ok=%b req=%b, want 1 0", ok, req);
      end
    end
    sb_q.push_back(mk(64'h8000_0004));
    advance = 1'b1;
    cycle();
    advance = 1'b0;
    n_vec++;
    if (ok !== 1'b0 || req !== 1'b1 || addr !== 64'h8000_0000) begin
      n_err++;
      $display("FAIL zero_bubble: got ok=%b req=%b addr=%h, want 0 1 80000000", ok, req, addr);
    end
    wait_ok(6);
  endtask

  task automatic test_redirect_wait();
    advance = 1'b1;
    cycle();
    advance  = 1'b0;
    rv_delay = 3;
    cycle();
    redirect    = 1'b1;
    redirect_pc = 64'h8000_0102;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (ok !== 1'b0 || req !== 1'b0) begin
        n_err++;
        $display("FAIL drop_after_redirect: got ok=%b req=%b, want 0 0", ok, req);
      end
      cycle();
    end
    n_vec++;
    if (req !== 1'b1 || addr !== 64'h8000_0100) begin
      n_err++;
      $display("FAIL redirect_addr: got req=%b addr=%h, want 1 80000100", req, addr);
    end
    rv_delay = 1;
    sb_q.push_back(mk(64'h8000_0100));
    wait_ok(6);
  endtask

  task automatic test_flush_req();
    gnt     = 1'b0;
    advance = 1'b1;
    cycle();
    advance = 1'b0;
    flush   = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_vec++;
      if (req !== 1'b1 || addr !== 64'h8000_0100) begin
        n_err++;
        $display("FAIL req_held: got req=%b addr=%h, want 1 80000100", req, addr);
      end
    end
    gnt = 1'b1;
    cycle();
    cycle();
    n_vec++;
    if (ok !== 1'b0) begin
      n_err++;
      $display("FAIL flushed_resp: got fetched_ok=%b, want 0", ok);
    end
    cycle();
    n_vec++;
    if (req !== 1'b1 || addr !== 64'h8000_0100) begin
      n_err++;
      $display("FAIL refetch_after_flush: got req=%b addr=%h, want 1 80000100", req, addr);
    end
    sb_q.push_back(mk(64'h8000_0104));
    wait_ok(6);
  endtask

  task automatic test_redirect_req();
    gnt     = 1'b0;
    advance = 1'b1;
    cycle();
    advance     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h9000_0013;
    cycle();
    redirect = 1'b0;
    n_vec++;
    if (req !== 1'b1 || addr !== 64'h8000_0108) begin
      n_err++;
      $display("FAIL addr_stable_on_redirect: got req=%b addr=%h, want 1 80000108", req, addr);
    end
    gnt = 1'b1;
    cycle();
    cycle();
    cycle();
    n_vec++;
    if (req !== 1'b1 || addr !== 64'h9000_0010) begin
      n_err++;
      $display("FAIL deferred_redirect: got req=%b addr=%h, want 1 90000010", req, addr);
    end
    sb_q.push_back(mk(64'h9000_0010));
    wait_ok(6);
  endtask

  task automatic test_dont_fetch();
    advance = 1'b1;
    cycle();
    advance    = 1'b0;
    dont_fetch = 1'b1;
    sb_q.push_back(mk(64'h9000_0014));
    wait_ok(6);
    advance = 1'b1;
    cycle();
    advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (req !== 1'b0 || ok !== 1'b0) begin
        n_err++;
        $display("FAIL dont_fetch_block: got req=%b ok=%b, want 0 0", req, ok);
      end
      cycle();
    end
    dont_fetch = 1'b0;
    cycle();
    n_vec++;
    if (req !== 1'b1 || addr !== 64'h9000_0018) begin
      n_err++;
      $display("FAIL dont_fetch_release: got req=%b addr=%h, want 1 90000018", req, addr);
    end
    sb_q.push_back(mk(64'h9000_0018));
    wait_ok(6);
  endtask

  task automatic test_reset_wait();
    advance = 1'b1;
    cycle();
    advance  = 1'b0;
    rv_delay = 3;
    cycle();
    rst = 1'b1;
    cycle();
    n_vec++;
    if ({req, ok} !== 2'b00 || inst !== NOP || pc_o !== 64'h0) begin
      n_err++;
      $display("FAIL reset_in_wait: got req=%b ok=%b inst=%h pc=%h, want 0 0 %h 0", req, ok, inst, pc_o, NOP);
    end
    rst      = 1'b0;
    rv_delay = 1;
    cycle();
    n_vec++;
    if (req !== 1'b1 || addr !== 64'h8000_0000) begin
      n_err++;
      $display("FAIL reset_pc: got req=%b addr=%h, want 1 80000000", req, addr);
    end
    sb_q.push_back(mk(64'h8000_0000));
    wait_ok(6);
  endtask

  task automatic test_wrap_and_kill_hold();
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle();
    redirect = 1'b0;
    n_vec++;
    if (ok !== 1'b0 || inst !== NOP) begin
      n_err++;
      $display("FAIL kill_in_hold: got ok=%b inst=%h, want 0 %h", ok, inst, NOP);
    end
    cycle();
    n_vec++;
    if (req !== 1'b1 || addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      n_err++;
      $display("FAIL top_addr: got req=%b addr=%h, want 1 fffffffffffffff8", req, addr);
    end
    sb_q.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC));
    wait_ok(6);
    advance = 1'b1;
    cycle();
    advance = 1'b0;
    n_vec++;
    if (req !== 1'b1 || addr !== 64'h0) begin
      n_err++;
      $display("FAIL pc_wrap: got req=%b addr=%h, want 1 0", req, addr);
    end
    sb_q.push_back(mk(64'h0));
    wait_ok(6);
    flush   = 1'b1;
    advance = 1'b1;
    cycle();
    flush   = 1'b0;
    advance = 1'b0;
    n_vec++;
    if (ok !== 1'b0 || inst !== NOP) begin
      n_err++;
      $display("FAIL flush_advance: got ok=%b inst=%h, want 0 %h", ok, inst, NOP);
    end
    cycle();
    sb_q.push_back(mk(64'h4));
    wait_ok(6);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    prev_ok     = 1'b0;
    held_inst   = '0;
    held_pc     = '0;
    pend        = 1'b0;
    cnt         = 0;
    rv_delay    = 1;
    paddr       = '0;
    rst         = 1'b1;
    dont_fetch  = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    advance     = 1'b0;
    gnt         = 1'b1;
    rvalid      = 1'b0;
    rdata       = '0;

    test_reset();
    test_first_fetch();
    test_hold_advance();
    test_redirect_wait();
    test_flush_req();
    test_redirect_req();
    test_dont_fetch();
    test_reset_wait();
    test_wrap_and_kill_hold();

    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d fetches outstanding, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
